// File: rtl/bit_serializer_pkg.sv
// Shared types and frame-length helper for the bit serializer.
// BIT_SERIALIZER_PARITY_EN appends an even-parity bit to every frame.
package bit_serializer_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

`ifdef BIT_SERIALIZER_PARITY_EN
    localparam bit PARITY_EN = 1'b1;
`else
    localparam bit PARITY_EN = 1'b0;
`endif

    function automatic int flen(input int width, input bit parity);
        return parity ? width + 1 : width;
    endfunction

endpackage

// File: rtl/bit_serializer_cnt.sv
// Modulo-FLEN bit-position counter with clear, enable and a last-bit flag.
module bit_serializer_cnt #(
    parameter int FLEN = 8,
    parameter int CW   = $clog2(FLEN + 1)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          clear,
    input  logic          enable,
    output logic [CW-1:0] count,
    output logic          last
);

    localparam logic [CW-1:0] LAST_IDX = CW'(FLEN - 1);

    logic [CW-1:0] count_reg;

    always_ff @(posedge clk) begin
        if (!reset) begin
            count_reg <= '0;
        end else if (clear) begin
            count_reg <= '0;
        end else if (enable) begin
            count_reg <= (count_reg == LAST_IDX) ? '0 : count_reg + CW'(1);
        end
    end

    assign count = count_reg;
    assign last  = (count_reg == LAST_IDX);

endmodule

// File: rtl/bit_serializer.sv
// Parallel-in/serial-out stage feeding the 010/101 sequence detectors.
// Optional BIT_SERIALIZER_PARITY_EN adds a trailing even-parity bit per frame.
module bit_serializer
    import bit_serializer_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load_valid,
    input  logic [WIDTH-1:0] load_data,
    output logic             load_ready,
    output logic             x_out,
    output logic             x_valid,
    output logic             busy,
    output logic             done
);

    localparam int FLEN = flen(WIDTH, PARITY_EN);
    localparam int CW   = $clog2(FLEN + 1);
    localparam logic [CW-1:0] PENULT = CW'(FLEN - 2);

    state_t state_reg, state_next;
    logic [WIDTH-1:0] shift_reg;
    logic x_out_reg, x_valid_reg, busy_reg, done_reg;
    logic [CW-1:0] count;
    logic last;
    logic in_shift, last_bit, accept, advance, done_next;
    logic first_bit, next_data_bit, next_bit;
    logic [WIDTH-1:0] loaded_shifted, shift_shifted;

    assign in_shift   = (state_reg == SHIFT);
    assign last_bit   = in_shift && last;
    assign load_ready = !in_shift || last;
    assign accept     = load_valid && load_ready;
    assign advance    = in_shift && !last;
    // Registered done must be high while the last bit is on x_out,
    // so it is raised on the edge that moves onto that bit.
    assign done_next  = advance && (count == PENULT);

    bit_serializer_cnt #(
        .FLEN (FLEN),
        .CW   (CW)
    ) u_cnt (
        .clk    (clk),
        .reset  (reset),
        .clear  (accept || last_bit),
        .enable (advance),
        .count  (count),
        .last   (last)
    );

    always_comb begin
        state_next = state_reg;
        if (accept) begin
            state_next = SHIFT;
        end else if (last_bit) begin
            state_next = IDLE;
        end
    end

    // The first bit goes straight to x_out; the shift register keeps the rest.
    assign first_bit      = MSB_FIRST ? load_data[WIDTH-1] : load_data[0];
    assign next_data_bit  = MSB_FIRST ? shift_reg[WIDTH-1] : shift_reg[0];
    assign loaded_shifted = MSB_FIRST ? (load_data << 1) : (load_data >> 1);
    assign shift_shifted  = MSB_FIRST ? (shift_reg << 1) : (shift_reg >> 1);

`ifdef BIT_SERIALIZER_PARITY_EN
    logic parity_reg;
    // With parity the final (done) position is the parity slot.
    assign next_bit = done_next ? parity_reg : next_data_bit;
`else
    assign next_bit = next_data_bit;
`endif

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_reg   <= IDLE;
            shift_reg   <= '0;
            x_out_reg   <= 1'b0;
            x_valid_reg <= 1'b0;
            busy_reg    <= 1'b0;
            done_reg    <= 1'b0;
`ifdef BIT_SERIALIZER_PARITY_EN
            parity_reg  <= 1'b0;
`endif
        end else begin
            state_reg <= state_next;
            if (accept) begin
                shift_reg   <= loaded_shifted;
                x_out_reg   <= first_bit;
                x_valid_reg <= 1'b1;
                busy_reg    <= 1'b1;
                done_reg    <= 1'b0;
`ifdef BIT_SERIALIZER_PARITY_EN
                parity_reg  <= ^load_data;
`endif
            end else if (advance) begin
                shift_reg   <= shift_shifted;
                x_out_reg   <= next_bit;
                x_valid_reg <= 1'b1;
                busy_reg    <= 1'b1;
                done_reg    <= done_next;
            end else begin
                x_out_reg   <= 1'b0;
                x_valid_reg <= 1'b0;
                busy_reg    <= 1'b0;
                done_reg    <= 1'b0;
            end
        end
    end

    assign x_out   = x_out_reg;
    assign x_valid = x_valid_reg;
    assign busy    = busy_reg;
    assign done    = done_reg;

endmodule
